seq_shift_add_mult: RTL and testbench

//  Parametrised sequential shift-add multiplier; next generation of the 4-bit multiplier core.

---
 rtl/seq_shift_add_mult_pkg.sv | 22 ++
 rtl/seq_shift_add_mult_if.sv | 24 ++
 rtl/seq_shift_add_mult_ctrl.sv | 59 +++++
 rtl/seq_shift_add_mult.sv | 104 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Build option: MULT_SIGNED_EN selects two's-complement operands/result.
package mult_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_ACCUM = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  localparam int unsigned STATE_O_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ACCUM = ENC_ACCUM,
    ST_DONE  = ENC_DONE
  } mult_state_e;

  // Zero-extend the state encoding onto the debug port width.
  function automatic logic [STATE_O_W-1:0] state_dbg(input mult_state_e s);
    return STATE_O_W'(s);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bus of the multiplier; master drives requests, slave returns results.
interface seq_shift_add_mult_if
  import mult_pkg::*;
#(
  parameter int unsigned W = 4
);
  logic                 start_i;
  logic [W-1:0]         a_i;
  logic [W-1:0]         b_i;
  logic [2*W-1:0]       y_o;
  logic                 done_o;
  logic                 busy_o;
  logic [STATE_O_W-1:0] state_o;

  modport master (
    output start_i, a_i, b_i,
    input  y_o, done_o, busy_o, state_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output y_o, done_o, busy_o, state_o
  );
endinterface

// File: rtl/seq_shift_add_mult_ctrl.sv
// Control FSM and iteration counter: IDLE -> ACCUM (W cycles) -> DONE -> IDLE.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned W = 4,
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output mult_state_e      state,
  output logic [CNT_W-1:0] cnt,
  output logic             load,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  mult_state_e state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Iteration counter: cleared on accept, advanced once per ACCUM cycle.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= '0;
    else if (state == ST_ACCUM)  cnt <= cnt + CNT_W'(1);
  end

  // Next-state and strobe decode; unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential W x W -> 2W shift-add multiplier, one multiplier bit per clock.
// Build option: MULT_SIGNED_EN (two's-complement operands and result).
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input logic                 clk,
  input logic                 rst,
  seq_shift_add_mult_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(W + 1);
`ifdef MULT_SIGNED_EN
  localparam int unsigned MAG_W = W + 1;
`else
  localparam int unsigned MAG_W = W;
`endif

  mult_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last;

  logic [MAG_W-1:0] a_reg;
  logic [W-1:0]     b_reg;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_nxt;
  logic [2*W-1:0]   y_reg;
  logic [2*W-1:0]   y_fin;
  logic             done_reg;
  logic             mbit;
  logic [MAG_W-1:0] a_mag_in;
  logic [W-1:0]     b_mag_in;

  mult_seq_ctrl #(.W(W)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start_i),
    .state (state),
    .cnt   (cnt),
    .load  (load),
    .last  (last)
  );

`ifdef MULT_SIGNED_EN
  logic       neg;
  logic [W:0] a_sx;

  // Magnitudes of the operands; a uses one extra bit so the most-negative value survives.
  always_comb begin
    a_sx     = {bus.a_i[W-1], bus.a_i};
    a_mag_in = a_sx[W] ? (~a_sx + MAG_W'(1)) : a_sx;
    b_mag_in = bus.b_i[W-1] ? (~bus.b_i + W'(1)) : bus.b_i;
    y_fin    = neg ? (~acc_nxt + (2*W)'(1)) : acc_nxt;
  end

  // Result sign, captured with the operands.
  always_ff @(posedge clk) begin
    if (rst)       neg <= 1'b0;
    else if (load) neg <= bus.a_i[W-1] ^ bus.b_i[W-1];
  end
`else
  // Unsigned build: operands pass straight through.
  always_comb begin
    a_mag_in = bus.a_i;
    b_mag_in = bus.b_i;
    y_fin    = acc_nxt;
  end
`endif

  // One partial product per cycle: add a shifted by cnt when multiplier bit cnt is set.
  always_comb begin
    mbit    = |(b_reg & (W'(1) << cnt));
    acc_nxt = mbit ? (acc + ((2*W)'(a_reg) << cnt)) : acc;
  end

  // Operand capture, accumulation and registered result/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      y_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= last;
      if (load) begin
        a_reg <= a_mag_in;
        b_reg <= b_mag_in;
        acc   <= '0;
      end else if (state == ST_ACCUM) begin
        acc <= acc_nxt;
      end
      if (last) y_reg <= y_fin;
    end
  end

  assign bus.y_o     = y_reg;
  assign bus.done_o  = done_reg;
  assign bus.busy_o  = (state != ST_IDLE);
  assign bus.state_o = state_dbg(state);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: W=4 directed cases, W=8 random sweep.
// Honours MULT_SIGNED_EN for the reference model.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult_if #(.W(4)) bus4 ();
  seq_shift_add_mult_if #(.W(8)) bus8 ();

  seq_shift_add_mult #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_shift_add_mult #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return 8'(p);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return 16'(p);
  endfunction

  // One W=4 product with cycle-exact done check; operands scrambled while busy.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus4.start_i = 1'b1; bus4.a_i = a; bus4.b_i = b;
    @(posedge clk);
    #1 bus4.start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq({tag, "_done"}, 64'(bus4.done_o), 64'(k == 5));
      if (k == 1) check_eq({tag, "_st_acc"}, 64'(bus4.state_o), 64'd1);
      if (k == 5) check_eq({tag, "_st_done"}, 64'(bus4.state_o), 64'd2);
      bus4.a_i = 4'($urandom);
      bus4.b_i = 4'($urandom);
      bus4.start_i = (k < 5) ? 1'($urandom) : 1'b0;
    end
    check_eq({tag, "_y"}, 64'(bus4.y_o), 64'(exp));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    int lat;
    bit seen;
    exp = model8(a, b);
    @(negedge clk);
    bus8.start_i = 1'b1; bus8.a_i = a; bus8.b_i = b;
    @(posedge clk);
    #1 bus8.start_i = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus8.done_o) begin seen = 1'b1; lat = k; end
    end
    check_eq("sw_lat", 64'(lat), 64'd9);
    check_eq("sw_y", 64'(bus8.y_o), 64'(exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus4.start_i = 1'b0; bus4.a_i = '0; bus4.b_i = '0;
    bus8.start_i = 1'b0; bus8.a_i = '0; bus8.b_i = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_y", 64'(bus4.y_o), 64'd0);
    check_eq("rst_done", 64'(bus4.done_o), 64'd0);
    check_eq("rst_busy", 64'(bus4.busy_o), 64'd0);
    check_eq("rst_state", 64'(bus4.state_o), 64'd0);
    rst = 1'b0;

    // T2: full-scale operands.
    run4(4'd15, 4'd15, model4(4'd15, 4'd15), "t2");

    // T1: reset in the middle of ACCUM.
    @(negedge clk);
    bus4.start_i = 1'b1; bus4.a_i = 4'd13; bus4.b_i = 4'd11;
    @(posedge clk);
    #1 bus4.start_i = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("t1_busy_pre", 64'(bus4.busy_o), 64'd1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t1_y", 64'(bus4.y_o), 64'd0);
      check_eq("t1_done", 64'(bus4.done_o), 64'd0);
      check_eq("t1_busy", 64'(bus4.busy_o), 64'd0);
      check_eq("t1_state", 64'(bus4.state_o), 64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_eq("t1_no_done", 64'(bus4.done_o), 64'd0);
    end
    check_eq("t1_idle", 64'(bus4.state_o), 64'd0);

    // T3: zero operands.
    run4(4'd9, 4'd0, 8'd0, "t3a");
    run4(4'd0, 4'd13, 8'd0, "t3b");

    // T4: start held high; results every W+2 cycles, none extra.
    @(negedge clk);
    bus4.start_i = 1'b1; bus4.a_i = 4'd3; bus4.b_i = 4'd5;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check_eq("t4_done", 64'(bus4.done_o), 64'((k % 6) == 5));
      if (bus4.done_o) check_eq("t4_y", 64'(bus4.y_o), 64'(model4(4'd3, 4'd5)));
    end
    bus4.start_i = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check_eq("t4_idle", 64'(bus4.busy_o), 64'd0);

    // T5: inputs toggle during ACCUM.
    run4(4'd6, 4'd7, 8'd42, "t5");

    // Random W=4 products.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom); rb = 4'($urandom);
      run4(ra, rb, model4(ra, rb), "r4");
    end

`ifdef MULT_SIGNED_EN
    // T6: signed corner cases.
    run4(4'h8, 4'h8, 8'd64, "t6a");
    run4(4'h8, 4'h7, 8'hC8, "t6b");
    run4(4'h7, 4'hF, 8'hF9, "t6c");
`endif

    // W=8 sweep, with explicit corners first.
    run8(8'hFF, 8'hFF);
    run8(8'h80, 8'h80);
    run8(8'h00, 8'hA5);
    for (int i = 0; i < 1000; i++) run8(8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
